// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises I-cache and D-cache line requests onto one pmem port.
// Round-robin between the two caches; the winner's address and write data are
// latched for the whole transaction, and the memory response is steered back
// only to the cache that owns the current transaction.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  // Line-offset bits are derived from the line width, never overridden.
  localparam int OFF_W = $clog2(LINE_W / 8);
  // Mask that clears the line-offset bits of a byte address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W)'((1 << OFF_W) - 1));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } state_t;

  // last_grant encoding: 0 = I-cache, 1 = D-cache.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic d_req;
  logic grant_d;
  logic grant_i;

  // Arbitration decision for the IDLE cycle: a lone requester wins, a contest
  // goes to the side that did not win last time.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | (last_grant_q == GRANT_I));
    grant_i = i_read & ~grant_d;
  end

  // Next-state and pmem request register logic.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          // A simultaneous read+write is illegal; the write-back wins.
          pmem_read_d    = d_read & ~d_write;
          pmem_write_d   = d_write;
          pmem_address_d = d_address & LINE_MASK;
          pmem_wdata_d   = d_wdata;
          last_grant_d   = GRANT_D;
          state_d        = SERVE_D;
        end else if (grant_i) begin
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = i_address & LINE_MASK;
          last_grant_d   = GRANT_I;
          state_d        = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        // Requester inputs are ignored here; only the memory ends the transaction.
        if (pmem_resp) begin
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = GAP;
        end
      end
      GAP: begin
        // One quiet cycle so the served cache can drop its request.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched pmem request registers; async reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Response steering: only the owner of the current transaction sees resp/data.
  always_comb begin
    i_resp  = (state_q == SERVE_I) & pmem_resp;
    d_resp  = (state_q == SERVE_D) & pmem_resp;
    i_rdata = i_resp ? pmem_rdata : '0;
    d_rdata = d_resp ? pmem_rdata : '0;
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter: grant order, latching, response
// steering, GAP timing, spurious responses and asynchronous reset.
`timescale 1ns/1ps
module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic [LINE_W-1:0] pmem_rdata = '0;

  int total = 0;
  int bad = 0;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_p;
  logic [LINE_W-1:0] pat_q;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rd, input logic wr);
    chk({tag, "_rd"}, LINE_W'(pmem_read), LINE_W'(rd));
    chk({tag, "_wr"}, LINE_W'(pmem_write), LINE_W'(wr));
  endtask

  // Reset asynchronously in the middle of the low clock phase, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pat_a5 = {(LINE_W/8){8'hA5}};
    pat_p  = {8{32'h1234_5678}};
    pat_q  = ~pat_p;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk_strobes("rst", 1'b0, 1'b0);
    chk("rst_addr", LINE_W'(pmem_address), '0);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_iresp", LINE_W'(i_resp), '0);
    chk("rst_dresp", LINE_W'(d_resp), '0);
    rst_n = 1'b1;
    $display("step: reset checked");

    // ---------------- single I read, resp after 5 cycles ----------------
    i_read = 1'b1;
    i_address = 32'h0000_104C;
    @(negedge clk);
    chk_strobes("i1_issue", 1'b1, 1'b0);
    chk("i1_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_1040));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("i1_wait_iresp", LINE_W'(i_resp), '0);
      chk("i1_wait_rd", LINE_W'(pmem_read), LINE_W'(1'b1));
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    pmem_rdata = pat_a5;
    #1;
    chk("i1_iresp", LINE_W'(i_resp), LINE_W'(1'b1));
    chk("i1_irdata", i_rdata, pat_a5);
    chk("i1_dresp", LINE_W'(d_resp), '0);
    chk("i1_drdata", d_rdata, '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    i_read = 1'b0;
    chk_strobes("i1_gap", 1'b0, 1'b0);
    @(negedge clk);
    chk_strobes("i1_idle", 1'b0, 1'b0);
    // spurious response in IDLE
    pmem_resp = 1'b1;
    #1;
    chk("idle_spur_iresp", LINE_W'(i_resp), '0);
    chk("idle_spur_dresp", LINE_W'(d_resp), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk_strobes("idle_spur_after", 1'b0, 1'b0);
    $display("step: single I read checked");

    // ---------------- contest after reset: D write wins, then I ----------------
    do_reset();
    i_read = 1'b1;
    i_address = 32'h0000_0213;
    d_write = 1'b1;
    d_address = 32'h8000_0020;
    d_wdata = pat_p;
    @(negedge clk);
    chk_strobes("c_dw", 1'b0, 1'b1);
    chk("c_dw_addr", LINE_W'(pmem_address), LINE_W'(32'h8000_0020));
    chk("c_dw_wdata", pmem_wdata, pat_p);
    // requester changes during SERVE_D must not reach pmem
    d_address = 32'hDEAD_BEE0;
    d_wdata = pat_q;
    @(negedge clk);
    chk("c_hold_addr", LINE_W'(pmem_address), LINE_W'(32'h8000_0020));
    chk("c_hold_wdata", pmem_wdata, pat_p);
    chk_strobes("c_hold", 1'b0, 1'b1);
    pmem_resp = 1'b1;
    pmem_rdata = pat_q;
    #1;
    chk("c_dresp", LINE_W'(d_resp), LINE_W'(1'b1));
    chk("c_iresp", LINE_W'(i_resp), '0);
    chk("c_irdata", i_rdata, '0);
    @(negedge clk);
    d_write = 1'b0;
    chk_strobes("c_gap", 1'b0, 1'b0);
    // spurious response in GAP, resp still high from the transaction
    #1;
    chk("gap_spur_iresp", LINE_W'(i_resp), '0);
    chk("gap_spur_dresp", LINE_W'(d_resp), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk_strobes("c_idle", 1'b0, 1'b0);
    @(negedge clk);
    chk_strobes("c_i_issue", 1'b1, 1'b0);
    chk("c_i_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_0200));
    pmem_resp = 1'b1;
    pmem_rdata = pat_a5;
    #1;
    chk("c_i_iresp", LINE_W'(i_resp), LINE_W'(1'b1));
    chk("c_i_irdata", i_rdata, pat_a5);
    @(negedge clk);
    pmem_resp = 1'b0;
    i_read = 1'b0;
    $display("step: contest/latch/gap checked");

    // ---------------- 6 back-to-back contested transactions ----------------
    do_reset();
    i_read = 1'b1;
    i_address = 32'h0000_1000;
    d_read = 1'b1;
    d_address = 32'h0000_2000;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = (k % 2) == 0;
      @(negedge clk);
      chk_strobes($sformatf("rr%0d_issue", k), 1'b1, 1'b0);
      chk($sformatf("rr%0d_addr", k), LINE_W'(pmem_address),
          exp_d ? LINE_W'(32'h0000_2000) : LINE_W'(32'h0000_1000));
      pmem_resp = 1'b1;
      pmem_rdata = LINE_W'(k + 1);
      #1;
      chk($sformatf("rr%0d_dresp", k), LINE_W'(d_resp), LINE_W'(exp_d));
      chk($sformatf("rr%0d_iresp", k), LINE_W'(i_resp), LINE_W'(!exp_d));
      @(negedge clk);
      pmem_resp = 1'b0;
      chk_strobes($sformatf("rr%0d_gap", k), 1'b0, 1'b0);
      @(negedge clk);
      chk_strobes($sformatf("rr%0d_idle", k), 1'b0, 1'b0);
      $display("step: rr transaction %0d to %s", k, exp_d ? "D" : "I");
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    @(negedge clk);
    pmem_resp = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;

    // ---------------- asynchronous reset during SERVE_I ----------------
    do_reset();
    i_read = 1'b1;
    i_address = 32'h0000_4000;
    @(negedge clk);
    chk_strobes("ar_serve_i", 1'b1, 1'b0);
    d_read = 1'b1;
    d_address = 32'h0000_3000;
    #3 rst_n = 1'b0;
    #1;
    chk_strobes("ar_async", 1'b0, 1'b0);
    chk("ar_addr", LINE_W'(pmem_address), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_strobes("ar_d_first", 1'b1, 1'b0);
    chk("ar_d_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_3000));
    pmem_resp = 1'b1;
    #1;
    chk("ar_dresp", LINE_W'(d_resp), LINE_W'(1'b1));
    @(negedge clk);
    pmem_resp = 1'b0;
    $display("step: async reset checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
